// File: rtl/sram_like_mem_resp.sv
// sram_like_mem_resp
// ------------------
// Responder side of an SRAM-like request/response handshake backed by a
// 2^ADDR_WIDTH x 32-bit word store. One transaction may be outstanding.
// The initiator holds req until addr_ok. addr_ok is a combinational pulse,
// raised once req has been held for ADDR_LAT cycles. data_ok is a registered
// pulse that arrives DATA_LAT cycles after the address is accepted.
//
// Optional feature: define SRAM_LIKE_MEM_RESP_RAND_STALL_EN to add 0..3
// pseudo-random extra address-wait cycles. They come from a 16-bit Fibonacci
// LFSR (taps 16,14,13,11, seed 16'hACE1) that steps once per accepted
// address. Without the macro the latencies are exactly ADDR_LAT / DATA_LAT.
//
// Ports
//   clk      in   1   clock, rising edge
//   rstn     in   1   synchronous active-low reset
//   req      in   1   request, held until addr_ok
//   wr       in   1   1 = write, 0 = read
//   size     in   2   00 byte, 01 halfword, 1x word
//   addr     in  32   byte address (bits above ADDR_WIDTH+1 alias)
//   wdata    in  32   write data, lanes aligned to addr[1:0]
//   addr_ok  out  1   address accepted (combinational pulse)
//   data_ok  out  1   transaction complete (registered pulse)
//   rdata    out 32   read data / pre-write word, held until next data_ok
module sram_like_mem_resp #(
  parameter int ADDR_WIDTH = 10,
  parameter int ADDR_LAT   = 1,   // 0..15
  parameter int DATA_LAT   = 2    // 1..15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // ADDR is the "req held, still counting" sub-state of IDLE.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [4:0]            hold_q, hold_d;      // ADDR_LAT + 3 extra fits in 5 bits
  logic [3:0]            dcnt_q, dcnt_d;
  logic                  data_ok_q, data_ok_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  wr_q, wr_d;
  logic [3:0]            mask_q, mask_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;

  logic [31:0]           mem_q [DEPTH];

  logic [1:0]            extra;
  logic [4:0]            thresh;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [3:0]            req_mask;
  logic                  commit;

  // High address bits are deliberately ignored: the store aliases.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], size[0]};

  assign req_idx = addr[ADDR_WIDTH+1:2];
  assign thresh  = 5'(ADDR_LAT) + {3'b000, extra};
  assign accept  = (state_q != ST_DATA) && req && (hold_q == thresh);

  // Byte-enable mask derived from size and the low address bits.
  always_comb begin
    req_mask = 4'b1111;
    if (!size[1]) begin
      if (!size[0]) req_mask = 4'b0001 << addr[1:0];
      else          req_mask = addr[1] ? 4'b1100 : 4'b0011;
    end
  end

`ifdef SRAM_LIKE_MEM_RESP_RAND_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign extra = lfsr_q[1:0];

  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk) begin
    if (!rstn) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign extra = 2'b00;
`endif

  // With DATA_LAT=1 the read happens in the accept cycle, before idx_q is loaded.
  assign rd_idx = (state_q == ST_DATA) ? idx_q : req_idx;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    dcnt_d    = dcnt_q;
    data_ok_d = 1'b0;
    wr_d      = wr_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    addr_ok   = 1'b0;

    case (state_q)
      ST_IDLE, ST_ADDR: begin
        if (req) begin
          if (accept) begin
            addr_ok   = rstn;
            state_d   = ST_DATA;
            hold_d    = 5'd0;
            dcnt_d    = 4'd0;
            wr_d      = wr;
            mask_d    = req_mask;
            idx_d     = req_idx;
            wdata_d   = wdata;
            data_ok_d = (DATA_LAT == 1);
          end else begin
            state_d = ST_ADDR;
            hold_d  = hold_q + 5'd1;
          end
        end else begin
          // A dropped request forfeits the hold cycles counted so far.
          state_d = ST_IDLE;
          hold_d  = 5'd0;
        end
      end
      ST_DATA: begin
        if (data_ok_q) begin
          // data_ok cycle: any req here is ignored; IDLE resumes next cycle.
          state_d = ST_IDLE;
        end else begin
          dcnt_d    = dcnt_q + 4'd1;
          // Register data_ok one cycle early so it lands DATA_LAT after accept.
          data_ok_d = ({1'b0, dcnt_q} + 5'd2) == 5'(DATA_LAT);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // rdata samples the word (pre-write for writes) as data_ok is launched.
  always_comb begin
    rdata_d = rdata_q;
    if (data_ok_d) rdata_d = mem_q[rd_idx];
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      hold_q    <= 5'd0;
      dcnt_q    <= 4'd0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
      wr_q      <= 1'b0;
      mask_q    <= 4'b0000;
      idx_q     <= '0;
      wdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      dcnt_q    <= dcnt_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      wr_q      <= wr_d;
      mask_q    <= mask_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
    end
  end

  // A write commits in its data_ok cycle; a reset edge then discards it.
  assign commit = data_ok_q && wr_q && rstn;

  // NOTE: storage has no reset so it maps onto a RAM macro and survives rstn.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign data_ok = data_ok_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_sram_like_mem_resp.sv
// Directed self-checking bench for sram_like_mem_resp (ADDR_LAT=1, DATA_LAT=2).
// A scoreboard queue holds the expected rdata for each accepted transaction.
// A word-level memory model and an LFSR model (when the stall macro is
// defined) supply every expected value.
module tb_sram_like_mem_resp;

  localparam int ADDR_LAT = 1;
  localparam int DATA_LAT = 2;
  localparam int BOUND    = 60;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  sram_like_mem_resp #(.ADDR_WIDTH(10), .ADDR_LAT(ADDR_LAT), .DATA_LAT(DATA_LAT)) u_dut (
    .clk(clk), .rstn(rstn), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  typedef struct {
    bit          known;
    logic [31:0] val;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] model[int];
  logic [15:0] m_lfsr;
  logic [31:0] last_rdata;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  // Expected number of req cycles up to and including the addr_ok cycle.
  function automatic int exp_alat();
`ifdef SRAM_LIKE_MEM_RESP_RAND_STALL_EN
    return ADDR_LAT + int'(m_lfsr[1:0]) + 1;
`else
    return ADDR_LAT + 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_addr(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (addr_ok !== 1'b1 && n < BOUND);
  endtask

  task automatic wait_data(output int n, output int stray);
    n = 0;
    stray = 0;
    do begin
      @(negedge clk);
      n++;
      if (addr_ok === 1'b1) stray++;
    end while (data_ok !== 1'b1 && n < BOUND);
  endtask

  // Record the accepted transaction: expected rdata, model update, LFSR step.
  task automatic accept_txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd);
    sb_t        e;
    int         idx;
    logic [3:0] m;
    idx     = int'(a[11:2]);
    e.known = model.exists(idx);
    e.val   = e.known ? model[idx] : 32'h0;
    sb_q.push_back(e);
    if (sz[1])      m = 4'b1111;
    else if (sz[0]) m = a[1] ? 4'b1100 : 4'b0011;
    else            m = 4'b0001 << a[1:0];
    if (w && (e.known || m == 4'b1111)) begin
      logic [31:0] nv;
      nv = e.val;
      for (int b = 0; b < 4; b++) if (m[b]) nv[8*b +: 8] = wd[8*b +: 8];
      model[idx] = nv;
    end
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  task automatic finish_txn(input string tag);
    int  n, stray;
    sb_t e;
    wait_data(n, stray);
    check({tag, "_dlat"}, n, DATA_LAT);
    check({tag, "_no_aok_in_data"}, stray, 0);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.known) check({tag, "_rdata"}, rdata, e.val);
    end
    last_rdata = rdata;
  endtask

  task automatic do_txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
    int n;
    tick();
    req = 1'b1; wr = w; size = sz; addr = a; wdata = wd;
    wait_addr(n);
    check({tag, "_alat"}, n, exp_alat());
    accept_txn(w, sz, a, wd);
    tick();
    req = 1'b0;
    finish_txn(tag);
  endtask

`ifdef SRAM_LIKE_MEM_RESP_RAND_STALL_EN
  logic        req_r;
  logic        addr_ok_r, data_ok_r;
  logic [31:0] rdata_r;

  sram_like_mem_resp #(.ADDR_WIDTH(10), .ADDR_LAT(0), .DATA_LAT(DATA_LAT)) u_dut_r (
    .clk(clk), .rstn(rstn), .req(req_r), .wr(1'b0), .size(2'b10), .addr(32'h0),
    .wdata(32'h0), .addr_ok(addr_ok_r), .data_ok(data_ok_r), .rdata(rdata_r)
  );
`endif

  initial begin
    int n, cnt;
    rstn = 1'b0; req = 1'b1; wr = 1'b0; size = 2'b10; addr = 32'h0; wdata = 32'h0;
    m_lfsr = 16'hACE1;
    last_rdata = 32'h0;
`ifdef SRAM_LIKE_MEM_RESP_RAND_STALL_EN
    req_r = 1'b0;
`endif

    // Reset state, with req high to show it is ignored while in reset
    tick();
    tick();
    @(negedge clk);
    check("rst_addr_ok", addr_ok, 1'b0);
    check("rst_data_ok", data_ok, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    tick();
    rstn = 1'b1; req = 1'b0;
    m_lfsr = 16'hACE1;

    // Word write then read back
    do_txn(1'b1, 2'b10, 32'h40, 32'h1234_5678, "w_word");
    do_txn(1'b0, 2'b10, 32'h40, 32'h0, "r_word");
    check("r_word_lit", last_rdata, 32'h1234_5678);

    // Byte and halfword merges
    do_txn(1'b1, 2'b10, 32'h40, 32'hAABB_CCDD, "w_base");
    do_txn(1'b1, 2'b00, 32'h41, 32'h0000_EE00, "w_sb");
    do_txn(1'b0, 2'b10, 32'h40, 32'h0, "r_sb");
    check("r_sb_lit", last_rdata, 32'hAABB_EEDD);
    do_txn(1'b1, 2'b01, 32'h43, 32'h1111_0000, "w_sh");
    do_txn(1'b0, 2'b01, 32'h40, 32'h0, "r_sh");
    check("r_sh_lit", last_rdata, 32'h1111_EEDD);

    // One-cycle req pulse must be dropped without side effects
    tick();
    req = 1'b1; wr = 1'b1; size = 2'b10; addr = 32'h40; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("pulse_aok", addr_ok, 1'b0);
    tick();
    req = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      cnt += int'(addr_ok) + int'(data_ok);
    end
    check("pulse_quiet", cnt, 0);
    do_txn(1'b0, 2'b10, 32'h40, 32'h0, "r_pulse");

    // req held through DATA: second addr_ok only after data_ok + ADDR_LAT
    tick();
    req = 1'b1; wr = 1'b0; size = 2'b10; addr = 32'h40;
    wait_addr(n);
    check("b2b_first_alat", n, exp_alat());
    accept_txn(1'b0, 2'b10, 32'h40, 32'h0);
    finish_txn("b2b_first");
    wait_addr(n);
    check("b2b_second_alat", n, exp_alat());
    accept_txn(1'b0, 2'b10, 32'h40, 32'h0);
    tick();
    req = 1'b0;
    finish_txn("b2b_second");
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      cnt += int'(data_ok);
    end
    check("b2b_single_dok", cnt, 0);

    // Aliasing of high address bits, byte lane 3, size 11
    do_txn(1'b1, 2'b11, 32'h1000_0100, 32'hCAFE_F00D, "w_alias");
    do_txn(1'b1, 2'b00, 32'h0000_0103, 32'h5A00_0000, "w_b3");
    do_txn(1'b0, 2'b00, 32'h0000_0100, 32'h0, "r_alias");
    check("r_alias_lit", last_rdata, 32'h5AFE_F00D);

    // Reset during DATA of a write discards it
    do_txn(1'b1, 2'b10, 32'h80, 32'h0, "w_zero");
    tick();
    req = 1'b1; wr = 1'b1; size = 2'b10; addr = 32'h80; wdata = 32'hDEAD_BEEF;
    wait_addr(n);
    check("rst_wr_alat", n, exp_alat());
    m_lfsr = lfsr_step(m_lfsr);
    tick();
    req = 1'b0; rstn = 1'b0;
    @(negedge clk);
    check("rst_wr_dok_pre", data_ok, 1'b0);
    tick();
    rstn = 1'b1;
    m_lfsr = 16'hACE1;
    @(negedge clk);
    check("rst_wr_rdata_clr", rdata, 32'h0);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      cnt += int'(data_ok);
    end
    check("rst_wr_no_dok", cnt, 0);
    do_txn(1'b0, 2'b10, 32'h80, 32'h0, "r_after_rst");
    check("r_after_rst_lit", last_rdata, 32'h0);

`ifdef SRAM_LIKE_MEM_RESP_RAND_STALL_EN
    // ADDR_LAT=0 instance: stall sequence follows the LFSR reference
    begin
      logic [15:0] r_lfsr;
      r_lfsr = 16'hACE1;
      for (int i = 0; i < 64; i++) begin
        tick();
        req_r = 1'b1;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (addr_ok_r !== 1'b1 && n < BOUND);
        check($sformatf("rand_alat_%0d", i), n, int'(r_lfsr[1:0]) + 1);
        check($sformatf("rand_range_%0d", i), (n >= 1 && n <= 4), 1'b1);
        r_lfsr = lfsr_step(r_lfsr);
        tick();
        req_r = 1'b0;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (data_ok_r !== 1'b1 && n < BOUND);
        check($sformatf("rand_dlat_%0d", i), n, DATA_LAT);
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_like_mem_resp.md
SRAM_LIKE_MEM_RESP -- requirements
Module: sram_like_mem_resp

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: word-index width; storage depth is 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter ADDR_LAT, default 1: cycles req must be held before addr_ok, range 0..15.
REQ-003 Parameter DATA_LAT, default 2: cycles from address acceptance to data_ok, range 1..15.
REQ-004 clk  input  1  the block's single clock; all state changes on its rising edge.
REQ-005 rstn  input  1  reset; synchronous, active-low.
REQ-006 req  input  1  initiator request; held high until addr_ok.
REQ-007 wr  input  1  1 = write, 0 = read; valid while req is high.
REQ-008 size  input  2  00 byte, 01 halfword, 10/11 word.
REQ-009 addr  input  32  byte address.
REQ-010 wdata  input  32  write data, byte lanes aligned to addr[1:0].
REQ-011 addr_ok  output  1  address accepted; one-cycle pulse.
REQ-012 data_ok  output  1  transaction complete; one-cycle pulse.
REQ-013 rdata  output  32  read data, valid in the data_ok cycle.

Function
REQ-014 The block SHALL implement states IDLE, ADDR, and DATA, with at most one outstanding transaction.
REQ-015 In IDLE with req=1, the block SHALL count hold cycles; addr_ok SHALL be asserted combinationally in the cycle when req=1 and hold count = ADDR_LAT (+ extra, see REQ-026); for ADDR_LAT=0 this is the first req cycle.
REQ-016 The block SHALL capture wr, size, addr, and wdata in the addr_ok cycle, then enter DATA with the counter cleared; ADDR is the waiting sub-state of IDLE when req is held.
REQ-017 If req drops before addr_ok, the block SHALL clear the hold count and accept no transaction.
REQ-018 In DATA, after DATA_LAT cycles the block SHALL register data_ok=1 for exactly one cycle, then return to IDLE.
REQ-019 addr_ok SHALL be 0 in DATA; a req present in DATA or in the data_ok cycle SHALL be ignored; the earliest new addr_ok is the cycle after data_ok (when ADDR_LAT=0).
REQ-020 Word index = captured addr[ADDR_WIDTH+1:2]; higher address bits SHALL be ignored (aliasing).
REQ-021 Read: rdata SHALL equal the full stored word at the word index, independent of size, and SHALL hold its value until the next data_ok.
REQ-022 Write byte mask: size 00 gives one-hot at addr[1:0]; size 01 gives 0011 if addr[1]=0, else 1100, with addr[0] ignored; size 1x gives 1111.
REQ-023 Write SHALL commit only the masked bytes of wdata, in the data_ok cycle; during a write, rdata SHALL present the pre-write word.
REQ-024 The block SHALL never assert addr_ok and data_ok in the same cycle.

Reset
REQ-025 While rstn=0, at the clock edge: state=IDLE, counters=0, data_ok=0, rdata=32'h0, addr_ok=0; an in-flight write SHALL be discarded; storage contents SHALL be left unchanged.

Configuration
REQ-026 Macro SRAM_LIKE_MEM_RESP_RAND_STALL_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset; advances once per accepted address) SHALL add lfsr[1:0] extra cycles (0..3) to the ADDR_LAT wait. Undefined: no LFSR, and latency is exactly ADDR_LAT/DATA_LAT.

Verification
REQ-027 Defaults, macro off: write word 0x1234_5678 at 0x40 with req held -> addr_ok in cycle 2 of req, data_ok 2 cycles later; a subsequent read of 0x40 -> rdata 0x1234_5678.
REQ-028 Word 0xAABB_CCDD at 0x40; sb wdata 0x0000_EE00 addr 0x41 -> read gives 0xAABB_EEDD; sh wdata 0x1111_0000 addr 0x43 -> read gives 0x1111_EEDD.
REQ-029 req pulsed one cycle with ADDR_LAT=1 -> no addr_ok, no data_ok, memory unchanged.
REQ-030 Second req asserted during DATA -> addr_ok first seen the cycle after data_ok plus ADDR_LAT; exactly one data_ok per transaction.
REQ-031 rstn low for one cycle during DATA of a write of 0xDEAD_BEEF to 0x80 (previously 0) -> no data_ok; a read of 0x80 gives 0.
REQ-032 Macro on, ADDR_LAT=0: over 64 reads, addr_ok delay stays within 0..3 cycles, and the delay sequence matches the LFSR reference model.
